cz_regfile: RTL and testbench

CZ_REGFILE -- requirements
Module: cz_regfile

---
 rtl/cz_regfile_pkg.sv | 21 ++
 rtl/cz_scoreboard.sv | 39 +++
 rtl/cz_regfile.sv | 93 +++++++++
 tb/tb_cz_regfile.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cz_regfile_pkg.sv
// rtl/cz_regfile_pkg.sv - shared encodings for the conditional-write register file
// Condition codes, flag-op thresholds and the condition evaluation helper.
package cz_regfile_pkg;

  localparam logic [1:0] CZ_ALWAYS  = 2'b00;
  localparam logic [1:0] CZ_IFZ     = 2'b01;
  localparam logic [1:0] CZ_IFC     = 2'b10;
  localparam logic [1:0] CZ_ALWAYS2 = 2'b11;

  localparam logic [2:0] OP_ADD     = 3'b000;
  localparam logic [2:0] OP_FLAGMAX = 3'b011;

  function automatic logic cond_met(input logic [1:0] cond, input logic c, input logic z);
    case (cond)
      CZ_IFC:  return c;
      CZ_IFZ:  return z;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/cz_scoreboard.sv
// rtl/cz_scoreboard.sv - pending-write busy bits with per-port lookup
// A set in the same cycle as a write-back clear wins; register 0 is never busy.
module cz_scoreboard
  import cz_regfile_pkg::*;
#(
  parameter int NREG = 8,
  parameter int NRD  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [AW-1:0]     wa,
  input  logic              sb_set,
  input  logic [AW-1:0]     sb_addr,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD-1:0]    rd_busy
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  always_comb begin
    busy_nxt = busy;
    if (we) busy_nxt[wa] = 1'b0;
    if (sb_set) busy_nxt[sb_addr] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) busy <= '0;
    else       busy <= busy_nxt;
  end

  for (genvar k = 0; k < NRD; k++) begin : g_port
    assign rd_busy[k] = busy[ra[k*AW +: AW]];
  end

endmodule

// File: rtl/cz_regfile.sv
// rtl/cz_regfile.sv - register file with carry/zero conditional write-back and scoreboard
// Optional same-cycle write-to-read bypass under macro CZ_REGFILE_BYPASS_EN.
module cz_regfile
  import cz_regfile_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 8,
  parameter int NRD  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DW-1:0]       pc_in,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [DW-1:0]       wd,
  input  logic [1:0]          cz_cond,
  input  logic [2:0]          flag_op,
  input  logic                c_in,
  input  logic                z_in,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*DW-1:0]   rd,
  output logic [NRD-1:0]      rd_busy,
  output logic                c_flag,
  output logic                z_flag,
  output logic                wr_commit,
  output logic [NREG*DW-1:0]  regs_flat
);

  logic [DW-1:0]  rf [NREG];
  logic           c_q;
  logic           z_q;
  logic           wr_commit_q;
  logic           commit;
  logic [NRD-1:0] sb_busy;

  // Condition sees only the flags held before this edge.
  assign commit = !reset && we && cond_met(cz_cond, c_q, z_q);

  always_ff @(posedge clk) begin
    rf[0] <= pc_in;
    if (reset) begin
      for (int i = 1; i < NREG; i++) rf[i] <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      wr_commit_q <= 1'b0;
    end else begin
      if (commit && (wa != '0)) rf[wa] <= wd;
      if (we && (flag_op == OP_ADD)) c_q <= c_in;
      if (we && (flag_op < OP_FLAGMAX)) z_q <= z_in;
      wr_commit_q <= commit && (wa != '0);
    end
  end

  cz_scoreboard #(
    .NREG (NREG),
    .NRD  (NRD),
    .AW   (AW)
  ) u_sb (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .wa      (wa),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .ra      (ra),
    .rd_busy (sb_busy)
  );

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] ra_k;
    logic          hit;
    assign ra_k = ra[k*AW +: AW];
`ifdef CZ_REGFILE_BYPASS_EN
    assign hit = commit && (wa != '0) && (ra_k == wa);
`else
    assign hit = 1'b0;
`endif
    assign rd[k*DW +: DW] = (ra_k == '0) ? '0 : (hit ? wd : rf[ra_k]);
    assign rd_busy[k]     = sb_busy[k] & ~hit;
  end

  for (genvar i = 0; i < NREG; i++) begin : g_flat
    assign regs_flat[i*DW +: DW] = rf[i];
  end

  assign c_flag    = c_q;
  assign z_flag    = z_q;
  assign wr_commit = wr_commit_q;

endmodule

// File: tb/tb_cz_regfile.sv
// tb/tb_cz_regfile.sv - directed table plus randomized model check for cz_regfile
module tb_cz_regfile;

`ifdef CZ_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  pc_in;
  logic         we;
  logic [2:0]   wa;
  logic [15:0]  wd;
  logic [1:0]   cz_cond;
  logic [2:0]   flag_op;
  logic         c_in;
  logic         z_in;
  logic         sb_set;
  logic [2:0]   sb_addr;
  logic [5:0]   ra;
  logic [31:0]  rd;
  logic [1:0]   rd_busy;
  logic         c_flag;
  logic         z_flag;
  logic         wr_commit;
  logic [127:0] regs_flat;

  int n_vec = 0;
  int n_err = 0;

  cz_regfile #(.DW(16), .NREG(8), .NRD(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .cz_cond   (cz_cond),
    .flag_op   (flag_op),
    .c_in      (c_in),
    .z_in      (z_in),
    .sb_set    (sb_set),
    .sb_addr   (sb_addr),
    .ra        (ra),
    .rd        (rd),
    .rd_busy   (rd_busy),
    .c_flag    (c_flag),
    .z_flag    (z_flag),
    .wr_commit (wr_commit),
    .regs_flat (regs_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [15:0] pc;
    logic        we;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [1:0]  cond;
    logic [2:0]  fop;
    logic        cin;
    logic        zin;
    logic        sbs;
    logic [2:0]  sba;
    logic [2:0]  ra0;
    logic        chk;
    logic [15:0] e_rd0;
    logic        e_bz0;
    logic        e_c;
    logic        e_z;
    logic        e_wc;
  } vec_t;

  function automatic vec_t mk(input logic rst, input logic [15:0] pc, input logic w,
                              input logic [2:0] a, input logic [15:0] d, input logic [1:0] cond,
                              input logic [2:0] fop, input logic cin, input logic zin,
                              input logic sbs, input logic [2:0] sba, input logic [2:0] ra0,
                              input logic chk, input logic [15:0] e_rd0, input logic e_bz0,
                              input logic e_c, input logic e_z, input logic e_wc);
    vec_t v;
    v.rst = rst; v.pc = pc; v.we = w; v.wa = a; v.wd = d; v.cond = cond; v.fop = fop;
    v.cin = cin; v.zin = zin; v.sbs = sbs; v.sba = sba; v.ra0 = ra0; v.chk = chk;
    v.e_rd0 = e_rd0; v.e_bz0 = e_bz0; v.e_c = e_c; v.e_z = e_z; v.e_wc = e_wc;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  vec_t         tbl[$];
  logic [15:0]  mrf[8];
  logic [15:0]  mr0;
  logic [7:0]   mbusy;
  logic         mc, mz, mwc, mcommit, hit;
  logic [2:0]   rak;
  logic [15:0]  erd;
  logic [127:0] eflat;
  logic [31:0]  r32;

  initial begin
    reset = 1'b1; pc_in = '0; we = 1'b0; wa = '0; wd = '0; cz_cond = '0; flag_op = 3'd7;
    c_in = 1'b0; z_in = 1'b0; sb_set = 1'b0; sb_addr = '0; ra = '0;

    //           rst pc       we wa wd        cnd fop ci zi sb sba ra chk e_rd0                   bz c  z  wc
    tbl.push_back(mk(1, 16'h0040, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 0, 0, 16'h0000,               0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0010, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 3, 1, 16'h0000,               0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0014, 1, 3, 16'h1234, 0, 7, 0, 0, 0, 0, 3, 1, BYP ? 16'h1234 : 16'h0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 16'h0018, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 3, 1, 16'h1234,               0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h001c, 1, 4, 16'hAAAA, 2, 0, 1, 0, 0, 0, 4, 1, 16'h0000,               0, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0020, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 4, 1, 16'h0000,               0, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0024, 1, 4, 16'hAAAA, 2, 0, 1, 0, 0, 0, 4, 1, BYP ? 16'hAAAA : 16'h0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 16'h0028, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 4, 1, 16'hAAAA,               0, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0040, 1, 0, 16'hFFFF, 0, 7, 0, 0, 0, 0, 0, 1, 16'h0000,               0, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0044, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 0, 1, 16'h0000,               0, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0048, 0, 0, 16'h0000, 0, 7, 0, 0, 1, 5, 5, 1, 16'h0000,               0, 1, 0, 0));
    tbl.push_back(mk(0, 16'h004c, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 5, 1, 16'h0000,               1, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0050, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 5, 1, 16'h0000,               1, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0054, 1, 5, 16'h5A5A, 1, 7, 0, 0, 0, 0, 5, 1, 16'h0000,               1, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0058, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 5, 1, 16'h0000,               0, 1, 0, 0));
    tbl.push_back(mk(0, 16'h005c, 1, 6, 16'h0606, 0, 7, 0, 0, 1, 6, 6, 1, BYP ? 16'h0606 : 16'h0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 16'h0060, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 6, 1, 16'h0606,               1, 1, 0, 0));
    tbl.push_back(mk(0, 16'h0064, 1, 2, 16'hBEEF, 0, 7, 0, 0, 0, 0, 2, 1, BYP ? 16'hBEEF : 16'h0, 0, 1, 0, 1));
    tbl.push_back(mk(0, 16'h0068, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 2, 1, 16'hBEEF,               0, 1, 0, 0));
    tbl.push_back(mk(0, 16'h006c, 1, 1, 16'h0101, 0, 1, 0, 1, 0, 0, 1, 1, BYP ? 16'h0101 : 16'h0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 16'h0070, 1, 5, 16'h5555, 1, 7, 0, 0, 0, 0, 5, 1, BYP ? 16'h5555 : 16'h0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 16'h0074, 0, 0, 16'h0000, 0, 7, 0, 0, 1, 0, 0, 1, 16'h0000,               0, 1, 1, 0));
    tbl.push_back(mk(0, 16'h0078, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 0, 1, 16'h0000,               0, 1, 1, 0));
    tbl.push_back(mk(0, 16'h007c, 1, 7, 16'h7777, 3, 0, 1, 0, 0, 0, 7, 1, BYP ? 16'h7777 : 16'h0, 0, 1, 0, 1));
    tbl.push_back(mk(1, 16'h0080, 1, 3, 16'h5555, 0, 0, 1, 1, 1, 7, 3, 1, 16'h1234,               0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0084, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 3, 1, 16'h0000,               0, 0, 0, 0));
    tbl.push_back(mk(0, 16'h0088, 0, 0, 16'h0000, 0, 7, 0, 0, 0, 0, 7, 1, 16'h0000,               0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst; pc_in = tbl[i].pc; we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
      cz_cond = tbl[i].cond; flag_op = tbl[i].fop; c_in = tbl[i].cin; z_in = tbl[i].zin;
      sb_set = tbl[i].sbs; sb_addr = tbl[i].sba; ra = {3'd0, tbl[i].ra0};
      #1;
      if (tbl[i].chk) begin
        check($sformatf("t%0d_rd0", i), {112'd0, rd[15:0]}, {112'd0, tbl[i].e_rd0});
        check($sformatf("t%0d_busy0", i), {127'd0, rd_busy[0]}, {127'd0, tbl[i].e_bz0});
      end
      @(posedge clk);
      #1;
      check($sformatf("t%0d_c", i), {127'd0, c_flag}, {127'd0, tbl[i].e_c});
      check($sformatf("t%0d_z", i), {127'd0, z_flag}, {127'd0, tbl[i].e_z});
      check($sformatf("t%0d_wc", i), {127'd0, wr_commit}, {127'd0, tbl[i].e_wc});
      check($sformatf("t%0d_r0", i), {112'd0, regs_flat[15:0]}, {112'd0, tbl[i].pc});
    end

    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      r32 = $urandom;
      reset   = (n == 0) || (r32[4:0] == 5'd0);
      we      = r32[5];
      wa      = r32[8:6];
      cz_cond = r32[10:9];
      flag_op = r32[13:11];
      c_in    = r32[14];
      z_in    = r32[15];
      sb_set  = (r32[17:16] == 2'd0);
      sb_addr = r32[20:18];
      ra      = r32[26:21];
      r32 = $urandom;
      wd    = r32[15:0];
      pc_in = r32[31:16];
      #1;
      mcommit = !reset && we && (cz_cond == 2'b00 || cz_cond == 2'b11 ||
                                 (cz_cond == 2'b10 && mc) || (cz_cond == 2'b01 && mz));
      if (n > 0) begin
        for (int k = 0; k < 2; k++) begin
          rak = ra[k*3 +: 3];
          hit = BYP && mcommit && (wa != 3'd0) && (rak == wa);
          erd = (rak == 3'd0) ? 16'h0 : (hit ? wd : mrf[rak]);
          check($sformatf("r%0d_rd%0d", n, k), {112'd0, rd[k*16 +: 16]}, {112'd0, erd});
          check($sformatf("r%0d_busy%0d", n, k), {127'd0, rd_busy[k]}, {127'd0, hit ? 1'b0 : mbusy[rak]});
        end
      end
      @(posedge clk);
      if (reset) begin
        for (int i = 0; i < 8; i++) mrf[i] = 16'h0;
        mc = 1'b0; mz = 1'b0; mbusy = 8'h0; mwc = 1'b0;
      end else begin
        if (mcommit && wa != 3'd0) mrf[wa] = wd;
        if (we && flag_op == 3'd0) mc = c_in;
        if (we && flag_op < 3'd3) mz = z_in;
        if (we) mbusy[wa] = 1'b0;
        if (sb_set && sb_addr != 3'd0) mbusy[sb_addr] = 1'b1;
        mwc = mcommit && (wa != 3'd0);
      end
      mr0 = pc_in;
      for (int i = 0; i < 8; i++) eflat[i*16 +: 16] = (i == 0) ? mr0 : mrf[i];
      #1;
      check($sformatf("r%0d_c", n), {127'd0, c_flag}, {127'd0, mc});
      check($sformatf("r%0d_z", n), {127'd0, z_flag}, {127'd0, mz});
      check($sformatf("r%0d_wc", n), {127'd0, wr_commit}, {127'd0, mwc});
      check($sformatf("r%0d_regs", n), regs_flat, eflat);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
